// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state encoding
//
// Purpose: the state encoding, default divisor and frame shape used by the
//          UART transmitter and by anything that decodes its line.
// Ports:   none (package).
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   // 50 MHz system clock, 115200 baud
   localparam int UART_DEFAULT_CLK_DIV = 434;

   // 8N1 frame
   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte write handshake into the UART transmitter
//
// Purpose: groups the valid/ready byte handshake feeding uart_tx.
// Ports:   i_wdata  byte to send
//          i_wvalid i_wdata valid this cycle
//          o_wready transmitter FIFO can accept a byte this cycle
// Modports: master = byte producer, slave = uart_tx.
interface uart_tx_if;

   logic [7:0] i_wdata;
   logic       i_wvalid;
   logic       o_wready;

   modport master (
      output i_wdata,
      output i_wvalid,
      input  o_wready
   );

   modport slave (
      input  i_wdata,
      input  i_wvalid,
      output o_wready
   );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count
//
// Purpose: generic power-of-two-deep FIFO; read data is the head entry and is
//          valid whenever o_empty is low.
// Ports:   i_clk, i_rst   clock, asynchronous active-high reset
//          i_push/i_wdata write one entry (ignored when full)
//          i_pop          drop the head entry (ignored when empty)
//          o_rdata        head entry
//          o_full/o_empty occupancy flags from the registered count
//          o_count        entries held, 0..DEPTH
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = i_push & ~o_full;
   assign do_pop  = i_pop & ~o_empty;

   assign o_full  = (count == (AW+1)'(DEPTH));
   assign o_empty = (count == '0);
   assign o_count = count;
   assign o_rdata = mem[rd_ptr];

   // storage needs no reset: entries are only read after being written
   always_ff @(posedge i_clk) begin
      if (do_push) begin
         mem[wr_ptr] <= i_wdata;
      end
   end

   // pointers wrap naturally at DEPTH since DEPTH is a power of two
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with input byte FIFO
//
// Purpose: queues bytes from the write handshake and serialises each as
//          start bit, 8 data bits LSB first, one stop bit; each bit lasts
//          CLK_DIV clocks. Queued bytes go out back-to-back with no idle gap.
// Ports:   i_clk, i_rst  clock, asynchronous active-high reset
//          wr            byte handshake (i_wdata/i_wvalid in, o_wready out)
//          o_tx          serial line, idle high, registered
//          o_busy        FIFO non-empty or frame in progress, registered
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = UART_DEFAULT_CLK_DIV,
   parameter int FIFO_DEPTH = 16
) (
   input  logic     i_clk,
   input  logic     i_rst,
   uart_tx_if.slave wr,
   output logic     o_tx,
   output logic     o_busy
);

   localparam int              CW        = $clog2(CLK_DIV);
   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0]   BAUD_LAST = CW'(CLK_DIV - 1);
   localparam logic [2:0]      LAST_BIT  = 3'(UART_DATA_BITS - 1);

   uart_state_t   state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   logic          push;
   logic          pop;
   logic          baud_end;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_rdata;
   logic [AW:0]   fifo_count;

   // ready comes from the registered count only, never from i_wvalid
   assign wr.o_wready = ~fifo_full;
   assign push        = wr.i_wvalid & ~fifo_full;
   assign baud_end    = (baud_cnt == BAUD_LAST);

   // a new frame is loaded from idle, or straight from the last stop-bit cycle
   assign pop = ~fifo_empty & ((state == ST_IDLE) | ((state == ST_STOP) & baud_end));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (push),
      .i_wdata (wr.i_wdata),
      .i_pop   (pop),
      .o_rdata (fifo_rdata),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_count (fifo_count)
   );

   // o_tx and o_busy are registered from the current state, so the line
   // trails the state by one clock; every bit still lasts CLK_DIV clocks.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         o_tx     <= 1'b1;
         o_busy   <= 1'b0;
      end else begin
         o_busy <= (state != ST_IDLE) || (fifo_count != '0);
         case (state)
            ST_IDLE: begin
               o_tx <= 1'b1;
               if (pop) begin
                  shift    <= fifo_rdata;
                  baud_cnt <= '0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               o_tx <= 1'b0;
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               o_tx <= shift[0];
               if (baud_end) begin
                  baud_cnt <= '0;
                  shift    <= {1'b0, shift[7:1]};
                  if (bit_idx == LAST_BIT) begin
                     state <= ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_STOP: begin
               o_tx <= 1'b1;
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift <= fifo_rdata;
                     state <= ST_START;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               o_tx  <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx
module tb_uart_tx;

   localparam int D     = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx, busy, tx2, busy2;

   uart_tx_if bus ();
   uart_tx_if bus2 ();

   uart_tx #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .wr     (bus.slave),
      .o_tx   (tx),
      .o_busy (busy)
   );

   uart_tx dut2 (
      .i_clk  (clk),
      .i_rst  (rst),
      .wr     (bus2.slave),
      .o_tx   (tx2),
      .o_busy (busy2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: a byte queue standing in for the FIFO, a frame timer of
   // 10*D clocks, and a queue of expected line levels. A byte is taken from
   // the queue when no frame is running (or the running one finishes on this
   // edge); its whole 10-bit frame then appears on the line one clock later.
   byte unsigned mq[$];
   bit           mline[$];
   int           fsm_left   = 0;
   bit           exp_tx     = 1'b1;
   bit           exp_busy   = 1'b0;
   bit           exp_wready = 1'b1;
   bit           m_acc, m_pre_busy;
   byte unsigned m_b;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         mline.delete();
         fsm_left   = 0;
         exp_tx     = 1'b1;
         exp_busy   = 1'b0;
         exp_wready = 1'b1;
      end else begin
         m_acc      = bus.i_wvalid && (mq.size() < DEPTH);
         m_pre_busy = (fsm_left != 0) || (mq.size() != 0);
         exp_tx     = (mline.size() != 0) ? mline.pop_front() : 1'b1;
         if (fsm_left != 0) fsm_left--;
         if (fsm_left == 0 && mq.size() != 0) begin
            m_b = mq.pop_front();
            for (int s = 0; s < D; s++) mline.push_back(1'b0);
            for (int i = 0; i < 8; i++)
               for (int s = 0; s < D; s++) mline.push_back(m_b[i]);
            for (int s = 0; s < D; s++) mline.push_back(1'b1);
            fsm_left = 10 * D;
         end
         if (m_acc) mq.push_back(bus.i_wdata);
         exp_busy   = m_pre_busy;
         exp_wready = (mq.size() < DEPTH);
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         check("line", tx, exp_tx);
         check("busy", busy, exp_busy);
         check("wready", bus.o_wready, exp_wready);
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", busy, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic span_check(input string tag, input int t0, input int exp_span);
      int n = 0;
      while (busy !== 1'b0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check(tag, cyc - t0, exp_span);
   endtask

   int          t0, n, lat, len, total, zeros, bsy;
   logic        lvl;
   logic [9:0]  pat;

   initial begin
      bus.i_wvalid  = 1'b0;
      bus.i_wdata   = 8'h00;
      bus2.i_wvalid = 1'b0;
      bus2.i_wdata  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_wready", bus.o_wready, 1);
      check("rst_tx2", tx2, 1);
      rst    = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(negedge clk);

      // single byte 0xA5
      bus.i_wdata  = 8'hA5;
      bus.i_wvalid = 1'b1;
      @(negedge clk);
      bus.i_wvalid = 1'b0;
      lat = 0;
      while (tx && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("a5_latency", lat, 2);
      pat = {1'b1, 8'hA5, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int s = 0; s < D; s++) begin
            check("a5_line", tx, pat[k]);
            if (k == 9 && s == D - 1) check("a5_busy_last", busy, 1);
            @(negedge clk);
         end
      end
      check("a5_busy_drop", busy, 0);
      wait_idle(100);

      // fill to full: 0x01..0x06, last one refused
      for (int i = 0; i < 6; i++) begin
         bus.i_wdata  = 8'(i + 1);
         bus.i_wvalid = 1'b1;
         check("fill_wready", bus.o_wready, (i < 5) ? 1 : 0);
         @(negedge clk);
         if (i == 0) t0 = cyc;
      end
      bus.i_wvalid = 1'b0;
      span_check("fill_span", t0, 2 + 5 * 10 * D);
      wait_idle(100);

      // hold 0x77 while full; accepted the cycle after the pop
      for (int i = 0; i < 5; i++) begin
         bus.i_wdata  = 8'($urandom);
         bus.i_wvalid = 1'b1;
         @(negedge clk);
         if (i == 0) t0 = cyc;
      end
      bus.i_wdata  = 8'h77;
      bus.i_wvalid = 1'b1;
      n = 0;
      while (!bus.o_wready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("hold_77", n, 10 * D + 1 - 4);
      @(negedge clk);
      bus.i_wvalid = 1'b0;
      span_check("free_span", t0, 2 + 6 * 10 * D);
      wait_idle(100);

      // ignored writes while full
      for (int i = 0; i < 5; i++) begin
         bus.i_wdata  = 8'($urandom);
         bus.i_wvalid = 1'b1;
         @(negedge clk);
         if (i == 0) t0 = cyc;
      end
      bus.i_wvalid = 1'b0;
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         bus.i_wdata  = 8'($urandom);
         bus.i_wvalid = 1'b1;
         check("ign_wready", bus.o_wready, 0);
         @(negedge clk);
         bus.i_wvalid = 1'b0;
      end
      span_check("ign_span", t0, 2 + 5 * 10 * D);
      wait_idle(100);

      // reset during data bit 3 of 0x3C with two bytes queued
      bus.i_wdata  = 8'h3C;
      bus.i_wvalid = 1'b1;
      @(negedge clk);
      t0 = cyc;
      bus.i_wdata = 8'h11;
      @(negedge clk);
      bus.i_wdata = 8'h22;
      @(negedge clk);
      bus.i_wvalid = 1'b0;
      n = 0;
      while (cyc < t0 + 2 + D + 3 * D + 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_bit3", tx, 1);
      #1 rst = 1'b1;
      #1;
      check("mid_rst_tx", tx, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_wready", bus.o_wready, 1);
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      zeros = 0;
      bsy   = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!tx) zeros++;
         if (busy) bsy++;
      end
      check("post_rst_zeros", zeros, 0);
      check("post_rst_busy", bsy, 0);

      // random traffic, including writes refused while full
      for (int i = 0; i < 500; i++) begin
         bus.i_wvalid = ($urandom_range(0, 3) == 0);
         bus.i_wdata  = 8'($urandom);
         @(negedge clk);
      end
      bus.i_wvalid = 1'b0;
      wait_idle(1000);

      // default divisor instance, 0x55 alternates the line every bit
      bus2.i_wdata  = 8'h55;
      bus2.i_wvalid = 1'b1;
      @(negedge clk);
      bus2.i_wvalid = 1'b0;
      n = 0;
      while (tx2 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("div_latency", n, 2);
      total = 0;
      for (int r = 0; r < 9; r++) begin
         lvl = tx2;
         check("div_level", lvl, r % 2);
         len = 0;
         while (tx2 === lvl && len < 1000) begin
            @(negedge clk);
            len++;
         end
         check("div_bit", len, 434);
         total += len;
      end
      len = 0;
      while (busy2 && len < 1000) begin
         @(negedge clk);
         len++;
      end
      check("div_stop", len, 434);
      total += len;
      check("div_frame", total, 4340);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion expected finish before timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-stream UART transmitter with an input FIFO. It sits directly downstream of `debug_port` inside `control`, consuming `o_uart_wdata`/`o_uart_wvalid` and returning `i_uart_wready`. This replaces the tie-off of `i_wready` to 1, so debug bytes are no longer dropped while a frame is on the line. It serialises each byte as 8N1, LSB first, on a single TX pin.

## Interface
- `CLK_DIV`, default 434: clock cycles per bit (50 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, default 16: byte entries; must be a power of two, at least 2.
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; one clock; asynchronous, active-high.
- `i_wdata`  in  8  byte to send.
- `i_wvalid`  in  1  `i_wdata` valid this cycle.
- `o_wready`  out  1  FIFO can accept a byte this cycle.
- `o_tx`  out  1  serial line, idle high, registered.
- `o_busy`  out  1  FIFO non-empty or frame in progress.

## Operation
- **Write handshake**
  - A byte is accepted on a rising edge where `i_wvalid && o_wready`.
  - `i_wvalid` while `o_wready` is low is ignored; no data is stored.
  - `o_wready` = !full, derived from the registered count only. It is never combinationally dependent on `i_wvalid`.
- **FIFO**
  - Read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
  - Pop on empty cannot occur, because the FSM pops only when the FIFO is non-empty.
- **FSM states**
  - IDLE: `o_tx`=1. If the FIFO is non-empty, pop into the shift register, clear the baud counter, go to START.
  - START: `o_tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `o_tx`=shift[0] for CLK_DIV cycles, then shift right. After index 7 completes, go to STOP.
  - STOP: `o_tx`=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go straight to START (no idle gap); otherwise go to IDLE.
- **Counters**
  - Baud counter counts 0..CLK_DIV-1; width is clog2(CLK_DIV).
  - Bit index is 3 bits.
- `o_busy` = (state != IDLE) || (count != 0).
- **Reset** (asynchronous; any state, including mid-frame)
  - Outputs: `o_tx`=1, `o_busy`=0, `o_wready`=1.
  - Internal state: FIFO emptied, state=IDLE, all counters 0.
  - A truncated frame is not resumed.

## Timing
- Write accepted at edge E into an empty FIFO with FSM in IDLE:
  - Edge E+1: the FSM pops.
  - Edge E+2: `o_tx` falls.
- Frame length is exactly 10*CLK_DIV cycles; each bit lasts exactly CLK_DIV cycles.
- Back-to-back bytes: the next start bit begins on the cycle after the last stop-bit cycle.
- Full FIFO:
  - `o_wready` is low while count == FIFO_DEPTH.
  - It returns high the cycle after the pop edge.
  - A write in that same cycle is accepted.
- The write handshake sustains one byte per cycle until full.

## Structure
- Shared package/header `uart_pkg` holds:
  - state encodings: IDLE=0, START=1, DATA=2, STOP=3;
  - `UART_DEFAULT_CLK_DIV`;
  - frame constants: 8 data bits, 1 stop bit.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop/full/empty/count) is instantiated here. It is also reusable on the Ethernet path.
- The FSM, baud counter and shift register live in `uart_tx`.
- Integration: `control` drives `i_wready` of `debug_port` from `uart_tx.o_wready`.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.

- **Single byte.** Write 0xA5.
  - `o_tx` holds each of these values for 4 cycles: 0 (start), 1,0,1,0,0,1,0,1 (data), 1 (stop).
  - Start bit falls 2 edges after the accepting edge.
  - `o_busy` drops the cycle after the stop bit ends.
- **Fill to full.** Write 0x01..0x06 on consecutive cycles.
  - Bytes 0x01..0x05 are accepted: one is popped immediately and 4 remain queued.
  - `o_wready` is low for 0x06, which is ignored.
  - Line output is 0x01..0x05, back-to-back, 200 cycles total, no gaps.
- **Write at the freeing edge.** Hold `i_wvalid` with 0x77 while full.
  - The byte is accepted the cycle after the pop.
  - It is transmitted after the queued bytes.
- **Reset mid-frame.** Assert `i_rst` during data bit 3 of 0x3C with 2 bytes queued.
  - `o_tx`=1 and `o_busy`=0 immediately.
  - After release, nothing is transmitted.
- **Ignored write.** `i_wvalid` pulses while `o_wready`=0.
  - FIFO count is unchanged.
  - No extra frame is sent.
- **Default divisor.** CLK_DIV=434, write 0x55.
  - Every bit lasts exactly 434 cycles.
  - Frame lasts 4340 cycles.
